// File: rtl/mwadd_pkg.sv
// Shared types and constants for the sequential multiword adder.
// Holds the FSM state type, slice width and the index-width helper.
package mwadd_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam int SLICE_W = 4;

    function automatic int idx_width(input int width);
        int nsl;
        nsl = width / SLICE_W;
        return (nsl <= 1) ? 1 : $clog2(nsl);
    endfunction

endpackage

// File: rtl/multiword_add_seq_csel.sv
// Combinational 4-bit carry-select adder slice.
// Both carry-in results are formed in parallel and cin picks one.
module csel_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] r0;
    logic [4:0] r1;

    // Precompute both carry cases, then select.
    always_comb begin
        r0 = {1'b0, a} + {1'b0, b};
        r1 = {1'b0, a} + {1'b0, b} + 5'd1;
        {cout, sum} = cin ? r1 : r0;
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential wide adder: one 4-bit slice walked over WIDTH/4 nibbles.
// Define MWADD_SUB_EN to add a 'sub' port for a - b.
module multiword_add_seq
    import mwadd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef MWADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSL = WIDTH / SLICE_W;
    localparam int IW = idx_width(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(NSL - 1);

    state_t             state;
    state_t             state_nx;
    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   b_in;
    logic               cin_in;
    logic               carry;
    logic [IW-1:0]      idx;
    logic [SLICE_W-1:0] sa;
    logic [SLICE_W-1:0] sb;
    logic [SLICE_W-1:0] s4;
    logic               c4;

`ifdef MWADD_SUB_EN
    assign b_in   = sub ? ~b : b;
    assign cin_in = sub | cin;
`else
    assign b_in   = b;
    assign cin_in = cin;
`endif

    assign sa = opa[int'(idx)*SLICE_W +: SLICE_W];
    assign sb = opb[int'(idx)*SLICE_W +: SLICE_W];

    csel_add4 u_slice (
        .a    (sa),
        .b    (sb),
        .cin  (carry),
        .sum  (s4),
        .cout (c4)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state, accept/finish strobes and busy.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        busy     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST) begin
                    last     = 1'b1;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    // Operand capture and nibble-by-nibble accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                opa   <= a;
                opb   <= b_in;
                carry <= cin_in;
                idx   <= '0;
                sum   <= '0;
            end else if (state == RUN) begin
                sum[int'(idx)*SLICE_W +: SLICE_W] <= s4;
                carry <= c4;
                idx   <= last ? '0 : idx + IW'(1);
                if (last) begin
                    cout <= c4;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
